// File: rtl/laser_host.sv
// Host-side driver for the laser circle-cover engine: buffers one image, streams it
// into the engine, waits for DONE, then scores the returned centres by point coverage.
module laser_host #(
  parameter int NPTS    = 40,
  parameter int R2      = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       WR_EN,
  input  logic [5:0] WR_ADDR,
  input  logic [3:0] WR_X,
  input  logic [3:0] WR_Y,
  input  logic       START,
  output logic       READY,
  output logic       LRST,
  output logic [3:0] X,
  output logic [3:0] Y,
  input  logic [3:0] C1X,
  input  logic [3:0] C1Y,
  input  logic [3:0] C2X,
  input  logic [3:0] C2Y,
  input  logic       DONE,
  output logic       RES_VALID,
  output logic [3:0] RES_C1X,
  output logic [3:0] RES_C1Y,
  output logic [3:0] RES_C2X,
  output logic [3:0] RES_C2Y,
  output logic [5:0] SCORE,
  output logic       ERR,
  output logic [2:0] DBG_STATE
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_STREAM = 3'd1,
    S_WAIT   = 3'd2,
    S_SCORE  = 3'd3,
    S_REPORT = 3'd4
  } state_t;

  localparam logic [5:0]  LAST_IDX = 6'(NPTS - 1);
  localparam logic [5:0]  NPTS_W   = 6'(NPTS);
  localparam logic [15:0] WD_LAST  = 16'(TIMEOUT - 1);
  localparam logic [8:0]  R2_W     = 9'(R2);

  state_t          state, state_nxt;
  logic [7:0]      buf_mem [NPTS];
  logic [NPTS-1:0] valid;
  logic [5:0]      cnt;
  logic [15:0]     wd;
  logic [5:0]      acc;
  logic [3:0]      cap_c1x, cap_c1y, cap_c2x, cap_c2y;
  logic            wr_ok, all_valid, covered;
  logic [5:0]      stream_idx, score_idx;
  logic [7:0]      pt_next, pt_score;

  logic            lrst_d, res_valid_d, err_d;
  logic [3:0]      x_d, y_d, rc1x_d, rc1y_d, rc2x_d, rc2y_d;
  logic [5:0]      score_d;

  function automatic logic [8:0] dist2(input logic [3:0] px, input logic [3:0] py,
                                       input logic [3:0] cx, input logic [3:0] cy);
    logic [3:0] dx, dy;
    logic [8:0] ex, ey;
    dx = (px >= cx) ? px - cx : cx - px;
    dy = (py >= cy) ? py - cy : cy - py;
    ex = {5'd0, dx};
    ey = {5'd0, dy};
    return ex * ex + ey * ey;
  endfunction

  // Image buffer: writable only while idle; bitmap survives runs so an image can be re-run.
  assign wr_ok     = (state == S_IDLE) && WR_EN && (WR_ADDR < NPTS_W);
  assign all_valid = &valid;

  always_ff @(posedge CLK) begin
    if (wr_ok) buf_mem[WR_ADDR] <= {WR_X, WR_Y};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)        valid <= '0;
    else if (wr_ok) valid[WR_ADDR] <= 1'b1;
  end

  always_comb begin
    stream_idx = (state == S_STREAM && cnt != LAST_IDX) ? cnt + 6'd1 : 6'd0;
    score_idx  = (cnt < NPTS_W) ? cnt : 6'd0;
    pt_next    = buf_mem[stream_idx];
    pt_score   = buf_mem[score_idx];
    covered    = (dist2(pt_score[7:4], pt_score[3:0], cap_c1x, cap_c1y) <= R2_W) ||
                 (dist2(pt_score[7:4], pt_score[3:0], cap_c2x, cap_c2y) <= R2_W);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // SCORE spends one extra cycle (cnt == NPTS) so the last point lands in acc before REPORT.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (START && all_valid) state_nxt = S_STREAM;
      S_STREAM: if (cnt == LAST_IDX)    state_nxt = S_WAIT;
      S_WAIT: begin
        if (DONE)              state_nxt = S_SCORE;
        else if (wd == WD_LAST) state_nxt = S_IDLE;
      end
      S_SCORE:  if (cnt == NPTS_W)      state_nxt = S_REPORT;
      S_REPORT: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt     <= '0;
      wd      <= '0;
      acc     <= '0;
      cap_c1x <= '0;
      cap_c1y <= '0;
      cap_c2x <= '0;
      cap_c2y <= '0;
    end else begin
      if (state_nxt != state)                          cnt <= '0;
      else if (state == S_STREAM || state == S_SCORE)  cnt <= cnt + 6'd1;

      if (state_nxt != state)  wd <= '0;
      else if (state == S_WAIT) wd <= wd + 16'd1;

      if (state == S_WAIT && state_nxt == S_SCORE)         acc <= '0;
      else if (state == S_SCORE && cnt < NPTS_W && covered) acc <= acc + 6'd1;

      if (state == S_WAIT && DONE) begin
        cap_c1x <= C1X;
        cap_c1y <= C1Y;
        cap_c2x <= C2X;
        cap_c2y <= C2Y;
      end
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    lrst_d      = (state_nxt == S_IDLE);
    x_d         = 4'd0;
    y_d         = 4'd0;
    res_valid_d = (state_nxt == S_REPORT);
    err_d       = (state == S_WAIT) && (state_nxt == S_IDLE);
    score_d     = SCORE;
    rc1x_d      = RES_C1X;
    rc1y_d      = RES_C1Y;
    rc2x_d      = RES_C2X;
    rc2y_d      = RES_C2Y;
    if (state_nxt == S_STREAM) begin
      x_d = pt_next[7:4];
      y_d = pt_next[3:0];
    end
    if (state == S_SCORE && state_nxt == S_REPORT) begin
      score_d = acc;
      rc1x_d  = cap_c1x;
      rc1y_d  = cap_c1y;
      rc2x_d  = cap_c2x;
      rc2y_d  = cap_c2y;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      LRST      <= 1'b1;
      X         <= '0;
      Y         <= '0;
      RES_VALID <= 1'b0;
      ERR       <= 1'b0;
      SCORE     <= '0;
      RES_C1X   <= '0;
      RES_C1Y   <= '0;
      RES_C2X   <= '0;
      RES_C2Y   <= '0;
    end else begin
      LRST      <= lrst_d;
      X         <= x_d;
      Y         <= y_d;
      RES_VALID <= res_valid_d;
      ERR       <= err_d;
      SCORE     <= score_d;
      RES_C1X   <= rc1x_d;
      RES_C1Y   <= rc1y_d;
      RES_C2X   <= rc2x_d;
      RES_C2Y   <= rc2y_d;
    end
  end

  assign READY     = (state == S_IDLE);
  assign DBG_STATE = state;

endmodule

// File: tb/tb_laser_host.sv
// Directed bench for laser_host: the engine is modelled by driving DONE and centres
// by hand; every expected value below is hand-computed from the image contents.
module tb_laser_host;
  localparam int NPTS = 40;

  logic       CLK = 1'b0;
  logic       RST;
  logic       WR_EN;
  logic [5:0] WR_ADDR;
  logic [3:0] WR_X, WR_Y;
  logic       START;
  logic       READY, LRST;
  logic [3:0] X, Y;
  logic [3:0] C1X, C1Y, C2X, C2Y;
  logic       DONE;
  logic       RES_VALID;
  logic [3:0] RES_C1X, RES_C1Y, RES_C2X, RES_C2Y;
  logic [5:0] SCORE;
  logic       ERR;
  logic [2:0] DBG_STATE;

  int n_checks = 0;
  int n_err    = 0;
  logic [3:0] img_x [NPTS];
  logic [3:0] img_y [NPTS];

  laser_host #(.NPTS(NPTS), .R2(16), .TIMEOUT(100)) dut (
    .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_X(WR_X), .WR_Y(WR_Y),
    .START(START), .READY(READY), .LRST(LRST), .X(X), .Y(Y),
    .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y), .DONE(DONE),
    .RES_VALID(RES_VALID), .RES_C1X(RES_C1X), .RES_C1Y(RES_C1Y),
    .RES_C2X(RES_C2X), .RES_C2Y(RES_C2Y), .SCORE(SCORE), .ERR(ERR),
    .DBG_STATE(DBG_STATE)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load(input int n);
    for (int k = 0; k < n; k++) begin
      WR_EN = 1'b1; WR_ADDR = 6'(k); WR_X = img_x[k]; WR_Y = img_y[k];
      tick();
    end
    WR_EN = 1'b0; WR_ADDR = '0; WR_X = '0; WR_Y = '0;
  endtask

  // START, stream check, DONE with given centres, then result check.
  task automatic run_image(input logic [3:0] c1x, input logic [3:0] c1y,
                           input logic [3:0] c2x, input logic [3:0] c2y,
                           input logic [5:0] exp_score);
    START = 1'b1;
    tick();
    START = 1'b0;
    check("start_ready", READY, 0);
    check("start_lrst", LRST, 0);
    for (int k = 0; k < NPTS; k++) begin
      check("stream_x", X, img_x[k]);
      check("stream_y", Y, img_y[k]);
      tick();
    end
    check("post_stream_x", X, 0);
    check("post_stream_y", Y, 0);
    tick(); tick();
    check("wait_err", ERR, 0);
    check("wait_lrst", LRST, 0);
    DONE = 1'b1; C1X = c1x; C1Y = c1y; C2X = c2x; C2Y = c2y;
    tick();
    DONE = 1'b0; C1X = '0; C1Y = '0; C2X = '0; C2Y = '0;
    repeat (NPTS) tick();
    check("res_valid_early", RES_VALID, 0);
    tick();
    check("res_valid", RES_VALID, 1);
    check("score", SCORE, exp_score);
    check("res_c1x", RES_C1X, c1x);
    check("res_c1y", RES_C1Y, c1y);
    check("res_c2x", RES_C2X, c2x);
    check("res_c2y", RES_C2Y, c2y);
    check("report_lrst", LRST, 0);
    tick();
    check("res_valid_end", RES_VALID, 0);
    check("idle_lrst", LRST, 1);
    check("idle_ready", READY, 1);
  endtask

  initial begin
    RST = 1'b1; WR_EN = 1'b0; WR_ADDR = '0; WR_X = '0; WR_Y = '0; START = 1'b0;
    C1X = '0; C1Y = '0; C2X = '0; C2Y = '0; DONE = 1'b0;
    repeat (2) tick();
    check("rst_ready", READY, 1);
    check("rst_lrst", LRST, 1);
    check("rst_x", X, 0);
    check("rst_y", Y, 0);
    check("rst_res_valid", RES_VALID, 0);
    check("rst_err", ERR, 0);
    check("rst_score", SCORE, 0);
    check("rst_res_c1x", RES_C1X, 0);
    RST = 1'b0;
    tick();

    // Stream pattern (k mod 16, k/3); only 39 entries loaded first.
    for (int k = 0; k < NPTS; k++) begin
      img_x[k] = 4'(k % 16);
      img_y[k] = 4'(k / 3);
    end
    load(NPTS - 1);
    START = 1'b1;
    tick();
    START = 1'b0;
    check("partial_ready", READY, 1);
    check("partial_lrst", LRST, 1);
    check("partial_x", X, 0);
    tick();
    check("partial_ready2", READY, 1);

    // Final write and START together: START sees the old bitmap.
    WR_EN = 1'b1; WR_ADDR = 6'd39; WR_X = img_x[39]; WR_Y = img_y[39]; START = 1'b1;
    tick();
    WR_EN = 1'b0; WR_ADDR = '0; WR_X = '0; WR_Y = '0; START = 1'b0;
    check("same_cycle_ready", READY, 1);
    check("same_cycle_lrst", LRST, 1);
    // Against C1=(0,0): k=0..3 covered (d2 0,1,4,10), k=4 (4,1) gives 17.
    run_image(4'd0, 4'd0, 4'd15, 4'd15, 6'd4);

    for (int k = 0; k < NPTS; k++) begin img_x[k] = 4'd5; img_y[k] = 4'd5; end
    load(NPTS);
    run_image(4'd5, 4'd5, 4'd10, 4'd10, 6'd40);

    for (int k = 0; k < NPTS; k++) begin img_x[k] = 4'd0; img_y[k] = 4'd0; end
    load(NPTS);
    run_image(4'd15, 4'd15, 4'd15, 4'd15, 6'd0);

    for (int k = 0; k < NPTS; k++) begin
      img_x[k] = 4'd4; img_y[k] = (k < 20) ? 4'd0 : 4'd1;
    end
    load(NPTS);
    run_image(4'd0, 4'd0, 4'd15, 4'd15, 6'd20);

    for (int k = 0; k < NPTS; k++) begin
      img_x[k] = (k < 20) ? 4'd0 : 4'd1; img_y[k] = 4'd4;
    end
    load(NPTS);
    run_image(4'd0, 4'd0, 4'd15, 4'd15, 6'd20);

    // Timeout: DONE never comes; WAIT entered at edge t+40, ERR at edge t+140.
    START = 1'b1;
    tick();
    START = 1'b0;
    repeat (NPTS) tick();
    repeat (99) tick();
    check("to_err_early", ERR, 0);
    check("to_ready_early", READY, 0);
    tick();
    check("to_err", ERR, 1);
    check("to_lrst", LRST, 1);
    check("to_ready", READY, 1);
    check("to_res_valid", RES_VALID, 0);
    check("to_score_hold", SCORE, 20);
    tick();
    check("to_err_end", ERR, 0);

    // Reset in the middle of a stream; image is (0,4) for the first 20 points.
    START = 1'b1;
    tick();
    START = 1'b0;
    repeat (5) tick();
    check("mid_lrst", LRST, 0);
    check("mid_y", Y, 4);
    #2 RST = 1'b1;
    #1;
    check("mid_rst_lrst", LRST, 1);
    check("mid_rst_x", X, 0);
    check("mid_rst_y", Y, 0);
    check("mid_rst_ready", READY, 1);
    check("mid_rst_res_c2x", RES_C2X, 0);
    @(negedge CLK);
    RST = 1'b0;
    tick();
    START = 1'b1;
    tick();
    START = 1'b0;
    check("noreload_ready", READY, 1);
    check("noreload_lrst", LRST, 1);
    tick();
    check("noreload_y", Y, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
